// File: rtl/seq_match_pkg.sv
// ============================================================================
// Module   : seq_match_pkg
// Purpose  : Shared types and helpers for the seq_delay_matcher checker.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seq_match_pkg;

    typedef enum logic {
        MODE_EXACT = 1'b0,
        MODE_RANGE = 1'b1
    } mode_e;

    // A delay of 0 means 1; anything beyond the hardware depth clamps to it.
    function automatic int unsigned clamp_dly(input int unsigned cfg, input int unsigned max_dly);
        if (cfg == 0) begin
            return 1;
        end else if (cfg > max_dly) begin
            return max_dly;
        end
        return cfg;
    endfunction

    // Saturating increment for counters up to 32 bits wide.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [32:0] lim;
        lim = (33'd1 << width) - 33'd1;
        return ({1'b0, val} >= lim) ? val : val + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_match_chan.sv
// ============================================================================
// Module   : seq_match_chan
// Purpose  : One channel of the w ##N y / w ##[1:N] y checker with counters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_match_chan
    import seq_match_pkg::*;
#(
    parameter int MAX_DLY = 8,
    parameter int CNT_W   = 16,
    parameter int DW      = $clog2(MAX_DLY + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  mode_e            mode,
    input  logic [DW-1:0]    dly,
    input  logic             flush,
    input  logic             w,
    input  logic             y,
    output logic             match,
    output logic             fail,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic             busy
);

    // Bit i holds an attempt that reaches age i+1 at the coming edge.
    logic [MAX_DLY-1:0] r_age;
    logic [MAX_DLY-1:0] w_win;
    logic [MAX_DLY-1:0] w_last;
    logic [MAX_DLY-1:0] w_clr;
    logic [MAX_DLY-1:0] w_age_nxt;
    logic               w_match;
    logic               w_fail;

    always_comb begin
        w_win  = '0;
        w_last = '0;
        for (int i = 0; i < MAX_DLY; i++) begin
            w_win[i]  = (i < int'(dly));
            w_last[i] = (i == int'(dly) - 1);
        end
        w_match = 1'b0;
        w_fail  = 1'b0;
        w_clr   = w_last;
        if (mode == MODE_RANGE && y) begin
            w_match = |(r_age & w_win);
            w_clr   = w_win;
        end else begin
            w_match = y && |(r_age & w_last);
            w_fail  = !y && |(r_age & w_last);
        end
        if (flush) begin
            w_match = 1'b0;
            w_fail  = 1'b0;
            w_clr   = '1;
        end
        // The new attempt enters at bit 0 after the shift, so y never sees it this edge.
        w_age_nxt = ((r_age & ~w_clr) << 1) | MAX_DLY'(en && w);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_age     <= '0;
            match     <= 1'b0;
            fail      <= 1'b0;
            busy      <= 1'b0;
            match_cnt <= '0;
            fail_cnt  <= '0;
        end else begin
            r_age <= w_age_nxt;
            match <= w_match;
            fail  <= w_fail;
            busy  <= |w_age_nxt;
            if (w_match) begin
                match_cnt <= CNT_W'(sat_inc(32'(match_cnt), CNT_W));
            end
            if (w_fail) begin
                fail_cnt <= CNT_W'(sat_inc(32'(fail_cnt), CNT_W));
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_delay_matcher.sv
// ============================================================================
// Module   : seq_delay_matcher
// Purpose  : Multi-channel synthesizable temporal-sequence monitor (w ##N y).
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_delay_matcher
    import seq_match_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int MAX_DLY = 8,
    parameter int CNT_W   = 16,
    parameter int DW      = $clog2(MAX_DLY + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 cfg_mode,
    input  logic [DW-1:0]        cfg_dly,
    input  logic [NCH-1:0]       w,
    input  logic [NCH-1:0]       y,
    output logic [NCH-1:0]       match,
    output logic [NCH-1:0]       fail,
    output logic [NCH*CNT_W-1:0] match_cnt,
    output logic [NCH*CNT_W-1:0] fail_cnt,
    output logic [NCH-1:0]       busy
);

    logic          r_cfg_mode;
    logic [DW-1:0] r_cfg_dly;
    logic          w_flush;
    logic [DW-1:0] w_dly;
    mode_e         w_mode;

    // Raw config is compared so any write, even one clamping to the same N, flushes.
    assign w_flush = (cfg_mode != r_cfg_mode) || (cfg_dly != r_cfg_dly);
    assign w_dly   = DW'(clamp_dly(32'(cfg_dly), MAX_DLY));
    assign w_mode  = mode_e'(cfg_mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_mode <= 1'b0;
            r_cfg_dly  <= '0;
        end else begin
            r_cfg_mode <= cfg_mode;
            r_cfg_dly  <= cfg_dly;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        seq_match_chan #(
            .MAX_DLY (MAX_DLY),
            .CNT_W   (CNT_W),
            .DW      (DW)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .en        (en),
            .mode      (w_mode),
            .dly       (w_dly),
            .flush     (w_flush),
            .w         (w[c]),
            .y         (y[c]),
            .match     (match[c]),
            .fail      (fail[c]),
            .match_cnt (match_cnt[c*CNT_W +: CNT_W]),
            .fail_cnt  (fail_cnt[c*CNT_W +: CNT_W]),
            .busy      (busy[c])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_delay_matcher.sv
// ============================================================================
// Module   : tb_seq_delay_matcher
// Purpose  : Self-checking bench for seq_delay_matcher with a timestamp model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_delay_matcher;

    localparam int NCH     = 4;
    localparam int MAX_DLY = 8;
    localparam int CNT_W   = 4;
    localparam int DW      = $clog2(MAX_DLY + 1);
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 en;
    logic                 cfg_mode;
    logic [DW-1:0]        cfg_dly;
    logic [NCH-1:0]       w;
    logic [NCH-1:0]       y;
    logic [NCH-1:0]       match;
    logic [NCH-1:0]       fail;
    logic [NCH*CNT_W-1:0] match_cnt;
    logic [NCH*CNT_W-1:0] fail_cnt;
    logic [NCH-1:0]       busy;

    always #5 clk = ~clk;

    seq_delay_matcher #(
        .NCH     (NCH),
        .MAX_DLY (MAX_DLY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .cfg_mode  (cfg_mode),
        .cfg_dly   (cfg_dly),
        .w         (w),
        .y         (y),
        .match     (match),
        .fail      (fail),
        .match_cnt (match_cnt),
        .fail_cnt  (fail_cnt),
        .busy      (busy)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: each pending attempt is just the edge number at which it started.
    int             q[NCH][$];
    int             edge_n;
    int             m_cnt[NCH];
    int             f_cnt[NCH];
    logic [NCH-1:0] e_match, e_fail, e_busy;
    logic           p_mode;
    logic [DW-1:0]  p_dly;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            q[c].delete();
            m_cnt[c] = 0;
            f_cnt[c] = 0;
        end
        e_match = '0;
        e_fail  = '0;
        e_busy  = '0;
        p_mode  = 1'b0;
        p_dly   = '0;
    endtask

    task automatic model_step();
        int n;
        int age;
        bit fl;
        int keep[$];
        n = (cfg_dly == 0) ? 1 : ((int'(cfg_dly) > MAX_DLY) ? MAX_DLY : int'(cfg_dly));
        fl = (cfg_mode !== p_mode) || (cfg_dly !== p_dly);
        p_mode = cfg_mode;
        p_dly  = cfg_dly;
        edge_n++;
        for (int c = 0; c < NCH; c++) begin
            e_match[c] = 1'b0;
            e_fail[c]  = 1'b0;
            keep.delete();
            if (!fl) begin
                for (int k = 0; k < q[c].size(); k++) begin
                    age = edge_n - q[c][k];
                    if (cfg_mode && y[c] && age >= 1 && age <= n) e_match[c] = 1'b1;
                    else if (age == n) begin
                        if (!cfg_mode && y[c]) e_match[c] = 1'b1;
                        else e_fail[c] = 1'b1;
                    end else keep.push_back(q[c][k]);
                end
            end
            q[c] = keep;
            if (en && w[c]) q[c].push_back(edge_n);
            e_busy[c] = (q[c].size() != 0);
            if (e_match[c] && m_cnt[c] < CMAX) m_cnt[c]++;
            if (e_fail[c] && f_cnt[c] < CMAX) f_cnt[c]++;
        end
    endtask

    task automatic check_all();
        logic [NCH*CNT_W-1:0] em, ef;
        for (int c = 0; c < NCH; c++) begin
            em[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
            ef[c*CNT_W +: CNT_W] = CNT_W'(f_cnt[c]);
        end
        chk("match", 64'(match), 64'(e_match));
        chk("fail", 64'(fail), 64'(e_fail));
        chk("busy", 64'(busy), 64'(e_busy));
        chk("match_cnt", 64'(match_cnt), 64'(em));
        chk("fail_cnt", 64'(fail_cnt), 64'(ef));
    endtask

    task automatic tick(input logic e, input logic m, input logic [DW-1:0] d,
                        input logic [NCH-1:0] wi, input logic [NCH-1:0] yi);
        en = e; cfg_mode = m; cfg_dly = d; w = wi; y = yi;
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    // Reset is raised between edges to exercise the asynchronous clear.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_pulses", 64'({match, fail}), 64'd0);
        chk("rst_cnts", 64'({match_cnt, fail_cnt}), 64'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    logic          r_mode;
    logic [DW-1:0] r_dly;

    initial begin
        reset = 1'b1; en = 1'b0; cfg_mode = 1'b0; cfg_dly = '0; w = '0; y = '0;
        edge_n = 0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("init_outs", 64'({busy, match, fail}), 64'd0);
        reset = 1'b0;

        // Exact N=2 single attempt.
        do_reset();
        tick(1, 0, 2, 4'h0, 4'h0);
        tick(1, 0, 2, 4'h1, 4'h0);
        tick(1, 0, 2, 4'h0, 4'h0);
        tick(1, 0, 2, 4'h0, 4'h1);
        chk("t1_match", 64'(match[0]), 64'd1);
        tick(1, 0, 2, 4'h0, 4'h0);
        chk("t1_pulse_end", 64'(match[0]), 64'd0);
        chk("t1_mcnt", 64'(match_cnt[3:0]), 64'd1);
        chk("t1_fcnt", 64'(fail_cnt[3:0]), 64'd0);

        // Exact N=3 overlapping attempts.
        do_reset();
        tick(1, 0, 3, 4'h0, 4'h0);
        tick(1, 0, 3, 4'h1, 4'h0);
        tick(1, 0, 3, 4'h1, 4'h0);
        tick(1, 0, 3, 4'h0, 4'h0);
        tick(1, 0, 3, 4'h0, 4'h1);
        chk("t2_match", 64'(match[0]), 64'd1);
        tick(1, 0, 3, 4'h0, 4'h0);
        chk("t2_fail", 64'(fail[0]), 64'd1);
        tick(1, 0, 3, 4'h0, 4'h0);
        chk("t2_cnts", 64'({match_cnt[3:0], fail_cnt[3:0]}), 64'h11);

        // Range N=4: two attempts satisfied by one y, then a timeout.
        do_reset();
        tick(1, 1, 4, 4'h0, 4'h0);
        tick(1, 1, 4, 4'h1, 4'h0);
        tick(1, 1, 4, 4'h1, 4'h0);
        tick(1, 1, 4, 4'h0, 4'h0);
        tick(1, 1, 4, 4'h0, 4'h1);
        chk("t3_match", 64'(match[0]), 64'd1);
        chk("t3_busy", 64'(busy[0]), 64'd0);
        tick(1, 1, 4, 4'h0, 4'h0);
        chk("t3_mcnt", 64'(match_cnt[3:0]), 64'd1);
        tick(1, 1, 4, 4'h1, 4'h0);
        repeat (3) tick(1, 1, 4, 4'h0, 4'h0);
        tick(1, 1, 4, 4'h0, 4'h0);
        chk("t3_fail", 64'(fail[0]), 64'd1);

        // Config change flushes a pending attempt.
        do_reset();
        tick(1, 0, 5, 4'h0, 4'h0);
        tick(1, 0, 5, 4'h1, 4'h0);
        repeat (2) tick(1, 0, 5, 4'h0, 4'h0);
        tick(1, 0, 2, 4'h0, 4'h0);
        tick(1, 0, 2, 4'h1, 4'h0);
        tick(1, 0, 2, 4'h0, 4'h0);
        tick(1, 0, 2, 4'h0, 4'h1);
        chk("t4_match", 64'(match[0]), 64'd1);
        tick(1, 0, 2, 4'h0, 4'h0);
        chk("t4_fcnt", 64'(fail_cnt[3:0]), 64'd0);

        // Reset mid-flight, then delay clamping at both ends.
        do_reset();
        tick(1, 0, 3, 4'hF, 4'h0);
        tick(1, 0, 3, 4'hF, 4'h0);
        chk("t5_busy", 64'(busy), 64'hF);
        do_reset();
        tick(1, 0, 0, 4'h0, 4'h0);
        tick(1, 0, 0, 4'h1, 4'h0);
        tick(1, 0, 0, 4'h0, 4'h1);
        chk("t5_dly0", 64'(match[0]), 64'd1);
        tick(1, 0, 15, 4'h0, 4'h0);
        tick(1, 0, 15, 4'h2, 4'h0);
        repeat (7) tick(1, 0, 15, 4'h0, 4'h0);
        tick(1, 0, 15, 4'h0, 4'h0);
        chk("t5_dly15", 64'(fail[1]), 64'd1);

        // Counter saturation on channel 2.
        do_reset();
        tick(1, 0, 1, 4'h0, 4'h0);
        repeat (20) tick(1, 0, 1, 4'h4, 4'h4);
        tick(1, 0, 1, 4'h0, 4'h4);
        chk("t6_sat", 64'(match_cnt[11:8]), 64'd15);
        tick(1, 0, 1, 4'h0, 4'h0);
        chk("t6_hold", 64'(match_cnt[11:8]), 64'd15);
        chk("t6_others", 64'({match_cnt[15:12], match_cnt[7:0]}), 64'd0);
        chk("t6_fcnt", 64'(fail_cnt), 64'd0);

        // Randomized traffic with occasional reconfiguration and reset.
        do_reset();
        r_mode = 1'b0;
        r_dly  = 4'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            if ($urandom_range(0, 59) == 0) begin
                r_mode = 1'($urandom);
                r_dly  = DW'($urandom_range(0, 15));
            end
            tick(($urandom_range(0, 9) != 0), r_mode, r_dly,
                 NCH'($urandom), NCH'($urandom_range(0, 3) == 0 ? 0 : $urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_delay_matcher.md
Name: seq_delay_matcher

Overview:
- Multi-channel RTL temporal-sequence checker: per channel, detects the pattern "w then y after cfg_dly clocks", i.e. w ##N y.
- Range mode generalises this to w ##[1:N] y.
- Emits per-channel match/fail pulses and saturating counters.
- Sits beside the DUT as a synthesizable monitor, so the same checks run on hardware as in simulation assertions.

Parameters:
- NCH, 4, number of independent channels.
- MAX_DLY, 8, largest supported delay in clocks (>=1).
- CNT_W, 16, width of each per-channel match/fail counter.
- DW, $clog2(MAX_DLY+1), derived width of cfg_dly.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  1 = new attempts may start; pending attempts always continue.
- cfg_mode  input  1  0 = exact (##N), 1 = range (##[1:N]).
- cfg_dly  input  DW  N; 0 is treated as 1, values above MAX_DLY clamp to MAX_DLY.
- w  input  NCH  antecedent per channel.
- y  input  NCH  consequent per channel.
- match  output  NCH  registered 1-cycle pulse: an attempt succeeded.
- fail  output  NCH  registered 1-cycle pulse: an attempt expired unsatisfied.
- match_cnt  output  NCH*CNT_W  saturating match counts, channel 0 in LSBs.
- fail_cnt  output  NCH*CNT_W  saturating fail counts, channel 0 in LSBs.
- busy  output  NCH  channel has at least one pending attempt.

Behaviour:
- Reset (async assert, sync release):
  - All pending attempts cleared.
  - match, fail, busy and all counters = 0.
  - Reset asserted mid-attempt discards that attempt; no pulse is produced.
- Attempt start:
  - At edge t0 with en=1 and w[c]=1, channel c starts an attempt of age 0.
  - Each channel keeps a MAX_DLY-bit age vector that shifts by one per clock, so overlapping attempts are tracked independently (one new attempt per cycle max).
- Exact mode (cfg_mode=0): at edge t0+N, the attempt is evaluated against y[c] sampled at that edge.
  - y=1: match[c]=1 during the following cycle.
  - y=0: fail[c]=1 during the following cycle.
  - The attempt is then retired.
- Range mode (cfg_mode=1): at each edge, all pending attempts of age 1..N are eligible.
  - If y[c]=1, every eligible attempt is satisfied and retired (first match per attempt). match[c] pulses once, however many attempts were satisfied.
  - An attempt of age N not satisfied at that edge fails.
  - match and fail may both pulse in the same cycle only if distinct attempts are involved; in practice a y=1 satisfies all eligible attempts, so this cannot happen in range mode.
- Same-edge events:
  - w=1 and y=1 at the same edge: y does not satisfy the new (age 0) attempt.
  - y can satisfy an older attempt at that edge.
- Counters:
  - match_cnt[c] increments by 1 per match pulse; fail_cnt[c] increments by 1 per fail pulse.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Config change: any change of cfg_mode or cfg_dly (compared to registered copies) flushes all pending attempts in all channels.
  - No pulses are produced for flushed attempts.
  - An attempt may start at the same edge the change is detected.
- en=0: blocks new starts only; in-flight attempts complete normally.
- busy[c] = OR of channel c's age vector (registered); it is 0 in the cycle after the last attempt retires.
- Latency: w at t0 gives a pulse visible in cycle t0+N+1 (exact mode).

Decomposition:
- Package seq_match_pkg:
  - mode_e enum {MODE_EXACT, MODE_RANGE}.
  - Function clamp_dly(cfg, MAX_DLY).
  - Saturating-increment function.
- Sub-module seq_match_chan: one channel's age vector, match/fail logic and counters.
  - Instantiated NCH times by generate.
  - The top holds the config registers, the flush detect and output packing.

Test Plan:
1. Exact, N=2, ch0: w=1 at edge 5, y=1 at edge 7 -> match[0]=1 in cycle 8 only; match_cnt[0]=1, fail_cnt[0]=0.
2. Exact, N=3, overlapping: w=1 at edges 1 and 2; y=1 at edge 4, y=0 at edge 5 -> match at cycle 5, fail at cycle 6; counts 1/1.
3. Range, N=4: w at edges 10 and 11, y=1 at edge 13 -> a single match pulse at cycle 14, match_cnt=1, busy=0 at cycle 14. Then w at edge 20 with no y -> fail at cycle 25.
4. Config flush: exact N=5, w at edge 0, cfg_dly changed to 2 at edge 3 -> no match/fail for that attempt; a new w at edge 4 with y at edge 6 -> match at cycle 7.
5. Reset mid-op plus boundaries:
   - Reset asserted asynchronously at cycle 3 with attempts pending -> busy, outputs and counters 0 immediately.
   - cfg_dly=0 behaves as N=1.
   - cfg_dly=15 with MAX_DLY=8 behaves as N=8.
6. Saturation, CNT_W=4: 20 consecutive successful attempts on ch2 (exact N=1, w and y held high) -> match_cnt[2]=15 and stays 15; other channels unaffected.
